// File: rtl/aes_sbox_lane_bank.sv
// rtl/aes_sbox_lane_bank.sv - multi-lane AES forward/inverse S-Box with elastic valid/ready pipeline
module aes_sbox_lane_bank #(
    parameter int LANES    = 4,
    parameter int PIPE     = 1,
    parameter int INV_ONLY = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_inv,
    input  logic [8*LANES-1:0] in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               out_inv,
    output logic [8*LANES-1:0] out_data
);

    localparam int W = 8 * LANES;

    // Forward S-Box, entry 0 is leftmost.
    localparam logic [0:255][7:0] FWD_SBOX = {
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    // Inverse S-Box, entry 0 is leftmost.
    localparam logic [0:255][7:0] INV_SBOX = {
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    logic          lut_inv;
    logic [W-1:0]  lut_data;

    logic [PIPE-1:0] vld_q;
    logic [PIPE-1:0] inv_q;
    logic [W-1:0]    dat_q [PIPE];

    logic [PIPE-1:0] src_vld;
    logic [PIPE-1:0] src_inv;
    logic [W-1:0]    src_dat [PIPE];
    logic [PIPE:0]   rdy;
    logic [PIPE-1:0] take;
    logic [PIPE-1:0] drain;

    assign lut_inv = (INV_ONLY != 0) ? 1'b1 : in_inv;

    // Per-lane table lookup; in inverse-only builds the forward table is never referenced.
    for (genvar i = 0; i < LANES; i++) begin : g_lane
        if (INV_ONLY != 0) begin : g_inv_only
            assign lut_data[8*i +: 8] = INV_SBOX[in_data[8*i +: 8]];
        end else begin : g_both
            assign lut_data[8*i +: 8] = lut_inv ? INV_SBOX[in_data[8*i +: 8]]
                                                : FWD_SBOX[in_data[8*i +: 8]];
        end
    end

    // Source of each stage: the lookup result for stage 1, the previous stage otherwise.
    for (genvar k = 0; k < PIPE; k++) begin : g_src
        if (k == 0) begin : g_first
            assign src_vld[k] = in_valid;
            assign src_inv[k] = lut_inv;
            assign src_dat[k] = lut_data;
        end else begin : g_later
            assign src_vld[k] = vld_q[k-1];
            assign src_inv[k] = inv_q[k-1];
            assign src_dat[k] = dat_q[k-1];
        end
    end

    // Ready chain from the output back to the input: a stage accepts when empty or when its word moves on.
    always_comb begin
        logic [PIPE:0] r;
        r       = '0;
        r[PIPE] = out_ready;
        for (int k = PIPE - 1; k >= 0; k--) begin
            r[k] = !vld_q[k] || r[k+1];
        end
        rdy = r;
    end

    // Per-stage load and drain strobes derived from the ready chain.
    always_comb begin
        take  = '0;
        drain = '0;
        for (int k = 0; k < PIPE; k++) begin
            take[k]  = src_vld[k] && rdy[k];
            drain[k] = vld_q[k] && rdy[k+1];
        end
    end

    assign in_ready = rdy[0];

    // Stage registers: valid tracks occupancy, mode and data load only on a transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            inv_q <= '0;
            for (int k = 0; k < PIPE; k++) begin
                dat_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < PIPE; k++) begin
                vld_q[k] <= take[k] || (vld_q[k] && !drain[k]);
                if (take[k]) begin
                    inv_q[k] <= src_inv[k];
                    dat_q[k] <= src_dat[k];
                end
            end
        end
    end

    assign out_valid = vld_q[PIPE-1];
    assign out_inv   = inv_q[PIPE-1];
    assign out_data  = dat_q[PIPE-1];

endmodule

// File: tb/tb_aes_sbox_lane_bank.sv
// tb/tb_aes_sbox_lane_bank.sv - directed self-checking bench for aes_sbox_lane_bank
module tb_aes_sbox_lane_bank;

    logic clk;
    logic rst_n;

    logic        a_in_valid, a_in_ready, a_in_inv, a_out_valid, a_out_ready, a_out_inv;
    logic [31:0] a_in_data, a_out_data;
    logic        b_in_valid, b_in_ready, b_in_inv, b_out_valid, b_out_ready, b_out_inv;
    logic [31:0] b_in_data, b_out_data;
    logic        c_in_valid, c_in_ready, c_in_inv, c_out_valid, c_out_ready, c_out_inv;
    logic [31:0] c_in_data, c_out_data;
    logic         d_in_valid, d_in_ready, d_in_inv, d_out_valid, d_out_ready, d_out_inv;
    logic [127:0] d_in_data, d_out_data;

    int n_chk = 0;
    int n_err = 0;

    aes_sbox_lane_bank #(.LANES(4), .PIPE(1), .INV_ONLY(0)) u_a (
        .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready), .in_inv(a_in_inv),
        .in_data(a_in_data), .out_valid(a_out_valid), .out_ready(a_out_ready), .out_inv(a_out_inv),
        .out_data(a_out_data));

    aes_sbox_lane_bank #(.LANES(4), .PIPE(3), .INV_ONLY(0)) u_b (
        .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_inv(b_in_inv),
        .in_data(b_in_data), .out_valid(b_out_valid), .out_ready(b_out_ready), .out_inv(b_out_inv),
        .out_data(b_out_data));

    aes_sbox_lane_bank #(.LANES(4), .PIPE(2), .INV_ONLY(0)) u_c (
        .clk(clk), .rst_n(rst_n), .in_valid(c_in_valid), .in_ready(c_in_ready), .in_inv(c_in_inv),
        .in_data(c_in_data), .out_valid(c_out_valid), .out_ready(c_out_ready), .out_inv(c_out_inv),
        .out_data(c_out_data));

    aes_sbox_lane_bank #(.LANES(16), .PIPE(1), .INV_ONLY(1)) u_d (
        .clk(clk), .rst_n(rst_n), .in_valid(d_in_valid), .in_ready(d_in_ready), .in_inv(d_in_inv),
        .in_data(d_in_data), .out_valid(d_out_valid), .out_ready(d_out_ready), .out_inv(d_out_inv),
        .out_data(d_out_data));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] fwdq[$];
        logic [7:0] expq[$];
        logic [7:0] e;
        int n_next;
        int inv_done;
        int first_out;
        int stalls;
        logic [31:0] first_fwd;

        rst_n = 1'b0;
        a_in_valid = 0; a_in_inv = 0; a_in_data = '0; a_out_ready = 1;
        b_in_valid = 0; b_in_inv = 0; b_in_data = '0; b_out_ready = 1;
        c_in_valid = 0; c_in_inv = 0; c_in_data = '0; c_out_ready = 1;
        d_in_valid = 0; d_in_inv = 0; d_in_data = '0; d_out_ready = 1;
        tick();
        tick();

        chk("rst_a_valid", a_out_valid, 1'b0);
        chk("rst_a_data", a_out_data, 32'h0);
        chk("rst_a_inv", a_out_inv, 1'b0);
        chk("rst_c_valid", c_out_valid, 1'b0);
        chk("rst_d_data", d_out_data, 128'h0);

        rst_n = 1'b1;
        #1;
        chk("rst_a_ready", a_in_ready, 1'b1);
        tick();

        // Back-to-back forward / inverse / inverse words on the PIPE=1 bank
        a_in_valid = 1; a_in_inv = 0; a_in_data = 32'hFF530100;
        tick();
        chk("fwd_valid", a_out_valid, 1'b1);
        chk("fwd_data", a_out_data, 32'h16ED7C63);
        chk("fwd_inv", a_out_inv, 1'b0);
        a_in_inv = 1; a_in_data = 32'hFFED7C63;
        tick();
        chk("inv1_valid", a_out_valid, 1'b1);
        chk("inv1_data", a_out_data, 32'h7D530100);
        chk("inv1_inv", a_out_inv, 1'b1);
        a_in_data = 32'hFF530100;
        tick();
        chk("inv2_data", a_out_data, 32'h7D500952);
        a_in_valid = 0;
        tick();
        chk("a_idle_valid", a_out_valid, 1'b0);

        // Round-trip streaming on the PIPE=3 bank
        n_next = 0; inv_done = 0; first_out = -1; stalls = 0; first_fwd = '0;
        for (int i = 0; i < 3000 && inv_done < 256; i++) begin
            if (b_in_valid && !b_in_ready) stalls++;
            if (b_out_valid) begin
                if (first_out < 0) begin
                    first_out = i;
                    first_fwd = b_out_data;
                end
                if (!b_out_inv) begin
                    fwdq.push_back(b_out_data[7:0]);
                end else begin
                    e = (expq.size() > 0) ? expq.pop_front() : 8'hxx;
                    chk("rt_inverse", b_out_data, {4{e}});
                    inv_done++;
                end
            end
            if (fwdq.size() > 0) begin
                b_in_valid = 1; b_in_inv = 1;
                e = fwdq.pop_front();
                b_in_data = {4{e}};
            end else if (n_next < 256) begin
                b_in_valid = 1; b_in_inv = 0;
                b_in_data = {4{n_next[7:0]}};
                expq.push_back(n_next[7:0]);
                n_next++;
            end else begin
                b_in_valid = 0;
            end
            tick();
        end
        b_in_valid = 0;
        chk("rt_done_count", inv_done, 256);
        chk("rt_first_latency", first_out, 3);
        chk("rt_first_fwd", first_fwd, 32'h63636363);
        chk("rt_no_stall", stalls, 0);

        // Backpressure on the PIPE=2 bank
        c_out_ready = 0;
        c_in_valid = 1; c_in_inv = 0; c_in_data = 32'h00000000;
        tick();
        chk("bp_ready_b", c_in_ready, 1'b1);
        c_in_data = 32'h01010101;
        tick();
        c_in_data = 32'h53535353;
        #1;
        chk("bp_ready_c", c_in_ready, 1'b0);
        chk("bp_valid", c_out_valid, 1'b1);
        chk("bp_hold_a", c_out_data, 32'h63636363);
        tick();
        tick();
        chk("bp_stable_a", c_out_data, 32'h63636363);
        chk("bp_still_full", c_in_ready, 1'b0);
        c_out_ready = 1;
        #1;
        chk("bp_release_ready", c_in_ready, 1'b1);
        tick();
        c_in_valid = 0;
        chk("bp_out_b", c_out_data, 32'h7C7C7C7C);
        chk("bp_out_b_valid", c_out_valid, 1'b1);
        tick();
        chk("bp_out_c", c_out_data, 32'hEDEDEDED);
        chk("bp_out_c_valid", c_out_valid, 1'b1);
        tick();
        chk("bp_drained", c_out_valid, 1'b0);

        // Reset with two words in flight
        c_out_ready = 0;
        c_in_valid = 1; c_in_data = 32'h00000000;
        tick();
        c_in_data = 32'h01010101;
        tick();
        c_in_valid = 0;
        chk("mr_full_valid", c_out_valid, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("mr_valid_drop", c_out_valid, 1'b0);
        chk("mr_data_zero", c_out_data, 32'h0);
        tick();
        rst_n = 1'b1;
        #1;
        chk("mr_ready", c_in_ready, 1'b1);
        c_out_ready = 1;
        c_in_valid = 1; c_in_inv = 0; c_in_data = 32'hFFFFFFFF;
        tick();
        c_in_valid = 0;
        chk("mr_lat_not_yet", c_out_valid, 1'b0);
        tick();
        chk("mr_next_valid", c_out_valid, 1'b1);
        chk("mr_next_data", c_out_data, 32'h16161616);
        tick();

        // Inverse-only 16-lane bank ignores in_inv
        d_in_valid = 1; d_in_inv = 0; d_in_data = {16{8'h63}};
        tick();
        chk("io_valid", d_out_valid, 1'b1);
        chk("io_data", d_out_data, 128'h0);
        chk("io_inv", d_out_inv, 1'b1);
        d_in_inv = 1; d_in_data = {16{8'h16}};
        tick();
        d_in_valid = 0;
        chk("io_data2", d_out_data, {16{8'hFF}});
        tick();
        chk("io_idle", d_out_valid, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
